// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs (ALU, LSB) drained
// one entry per cycle onto a registered broadcast bus with round-robin priority.
module cdb_arbiter #(
  parameter int unsigned ROB_ADDR = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,

  input  logic                alu_valid,
  input  logic [ROB_ADDR-1:0] alu_robid,
  input  logic [31:0]         alu_val,
  output logic                alu_ready,

  input  logic                lsb_valid,
  input  logic [ROB_ADDR-1:0] lsb_robid,
  input  logic [31:0]         lsb_val,
  output logic                lsb_ready,

  output logic                cdb_valid,
  output logic [ROB_ADDR-1:0] cdb_robid,
  output logic [31:0]         cdb_val,
  output logic                cdb_src,
  output logic [15:0]         conflict_cnt
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ROB_ADDR + 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [EW-1:0]       alu_mem_q [DEPTH];
  logic [EW-1:0]       lsb_mem_q [DEPTH];

  logic [PW-1:0]       alu_rp_q, alu_rp_d, alu_wp_q, alu_wp_d;
  logic [PW-1:0]       lsb_rp_q, lsb_rp_d, lsb_wp_q, lsb_wp_d;
  logic [CW-1:0]       alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;

  src_e                prio_q, prio_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_ADDR-1:0] cdb_robid_q, cdb_robid_d;
  logic [31:0]         cdb_val_q, cdb_val_d;
  src_e                cdb_src_q, cdb_src_d;
  logic [15:0]         conflict_q, conflict_d;

  logic                alu_ne, lsb_ne, grant_lsb, run;
  logic                alu_push, lsb_push, alu_pop, lsb_pop;

  assign alu_ready = (alu_cnt_q < CW'(DEPTH));
  assign lsb_ready = (lsb_cnt_q < CW'(DEPTH));

  // Grants look only at registered counts, so a value pushed this cycle
  // cannot be popped before the next edge.
  always_comb begin
    alu_ne    = (alu_cnt_q != '0);
    lsb_ne    = (lsb_cnt_q != '0);
    grant_lsb = lsb_ne & (~alu_ne | (prio_q == SRC_LSB));
    run       = rdy_in & ~clear;
    alu_push  = run & alu_valid & alu_ready;
    lsb_push  = run & lsb_valid & lsb_ready;
    alu_pop   = run & alu_ne & ~grant_lsb;
    lsb_pop   = run & grant_lsb;
  end

  always_comb begin
    alu_rp_d    = alu_rp_q;
    alu_wp_d    = alu_wp_q;
    alu_cnt_d   = alu_cnt_q;
    lsb_rp_d    = lsb_rp_q;
    lsb_wp_d    = lsb_wp_q;
    lsb_cnt_d   = lsb_cnt_q;
    prio_d      = prio_q;
    cdb_valid_d = cdb_valid_q;
    cdb_robid_d = cdb_robid_q;
    cdb_val_d   = cdb_val_q;
    cdb_src_d   = cdb_src_q;
    conflict_d  = conflict_q;

    if (rdy_in && clear) begin
      alu_rp_d    = '0;
      alu_wp_d    = '0;
      alu_cnt_d   = '0;
      lsb_rp_d    = '0;
      lsb_wp_d    = '0;
      lsb_cnt_d   = '0;
      cdb_valid_d = 1'b0;
    end else if (run) begin
      if (alu_push) alu_wp_d = alu_wp_q + 1'b1;
      if (lsb_push) lsb_wp_d = lsb_wp_q + 1'b1;
      if (alu_pop)  alu_rp_d = alu_rp_q + 1'b1;
      if (lsb_pop)  lsb_rp_d = lsb_rp_q + 1'b1;
      alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(alu_pop);
      lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(lsb_pop);

      cdb_valid_d = alu_ne | lsb_ne;
      if (alu_pop) begin
        {cdb_robid_d, cdb_val_d} = alu_mem_q[alu_rp_q];
        cdb_src_d = SRC_ALU;
        prio_d    = SRC_LSB;
      end else if (lsb_pop) begin
        {cdb_robid_d, cdb_val_d} = lsb_mem_q[lsb_rp_q];
        cdb_src_d = SRC_LSB;
        prio_d    = SRC_ALU;
      end

      if (alu_ne && lsb_ne && (conflict_q != '1)) conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        alu_mem_q[i] <= '0;
        lsb_mem_q[i] <= '0;
      end
      alu_rp_q    <= '0;
      alu_wp_q    <= '0;
      alu_cnt_q   <= '0;
      lsb_rp_q    <= '0;
      lsb_wp_q    <= '0;
      lsb_cnt_q   <= '0;
      prio_q      <= SRC_ALU;
      cdb_valid_q <= 1'b0;
      cdb_robid_q <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= SRC_ALU;
      conflict_q  <= '0;
    end else begin
      if (alu_push) alu_mem_q[alu_wp_q] <= {alu_robid, alu_val};
      if (lsb_push) lsb_mem_q[lsb_wp_q] <= {lsb_robid, lsb_val};
      alu_rp_q    <= alu_rp_d;
      alu_wp_q    <= alu_wp_d;
      alu_cnt_q   <= alu_cnt_d;
      lsb_rp_q    <= lsb_rp_d;
      lsb_wp_q    <= lsb_wp_d;
      lsb_cnt_q   <= lsb_cnt_d;
      prio_q      <= prio_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_robid_q <= cdb_robid_d;
      cdb_val_q   <= cdb_val_d;
      cdb_src_q   <= cdb_src_d;
      conflict_q  <= conflict_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_robid    = cdb_robid_q;
  assign cdb_val      = cdb_val_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (ROB_ADDR=4, DEPTH=2) with hand-computed
// broadcast sequences checked by immediate assertions.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_robid, lsb_robid;
  logic [31:0] alu_val, lsb_val;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_robid;
  logic [31:0] cdb_val;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.ROB_ADDR(4), .DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .alu_valid(alu_valid), .alu_robid(alu_robid), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_robid(lsb_robid), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_val(cdb_val), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mk(input logic [3:0] r);
    return 32'h0000_0100 | {28'h0, r};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [3:0] r,
                         input logic [31:0] val, input logic s);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".robid"}, 64'(cdb_robid), 64'(r));
    chk({tag, ".val"},   64'(cdb_val),   64'(val));
    chk({tag, ".src"},   64'(cdb_src),   64'(s));
  endtask

  task automatic offer_alu(input logic [3:0] r, input logic [31:0] v);
    alu_valid = 1'b1; alu_robid = r; alu_val = v;
  endtask

  task automatic offer_lsb(input logic [3:0] r, input logic [31:0] v);
    lsb_valid = 1'b1; lsb_robid = r; lsb_val = v;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    alu_valid = 1'b0; alu_robid = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_robid = '0; lsb_val = '0;

    // reset state
    #3;
    chk_cdb("rst", 1'b0, 4'd0, 32'h0, 1'b0);
    chk("rst.conflict", 64'(conflict_cnt), 64'd0);
    chk("rst.alu_ready", 64'(alu_ready), 64'd1);
    chk("rst.lsb_ready", 64'(lsb_ready), 64'd1);
    tick(); tick();
    rst_in = 1'b1;

    // single ALU result, 2-cycle latency
    offer_alu(4'd3, 32'h11);
    tick(); alu_valid = 1'b0;
    chk("t1.c1.valid", 64'(cdb_valid), 64'd0);
    tick(); chk_cdb("t1.c2", 1'b1, 4'd3, 32'h11, 1'b0);
    tick(); chk_cdb("t1.c3", 1'b0, 4'd3, 32'h11, 1'b0);

    // LSB-only result returns prio to ALU
    offer_lsb(4'd7, 32'h77);
    tick(); lsb_valid = 1'b0;
    tick(); chk_cdb("t1b.c2", 1'b1, 4'd7, 32'h77, 1'b1);
    chk("t1b.conflict", 64'(conflict_cnt), 64'd0);
    tick(); chk("t1b.c3.valid", 64'(cdb_valid), 64'd0);

    // simultaneous offers, prio=0
    offer_alu(4'd1, 32'hA1); offer_lsb(4'd2, 32'hB2);
    tick(); alu_valid = 1'b0; lsb_valid = 1'b0;
    tick(); chk_cdb("t2.c2", 1'b1, 4'd1, 32'hA1, 1'b0);
    chk("t2.c2.conflict", 64'(conflict_cnt), 64'd1);
    tick(); chk_cdb("t2.c3", 1'b1, 4'd2, 32'hB2, 1'b1);
    chk("t2.c3.conflict", 64'(conflict_cnt), 64'd1);
    tick(); chk("t2.c4.valid", 64'(cdb_valid), 64'd0);

    // ALU backpressure with LSB kept busy; offer of 12 is held while full
    offer_alu(4'd4, mk(4'd4)); offer_lsb(4'd8, mk(4'd8));
    tick();
    chk("t3.c1.valid", 64'(cdb_valid), 64'd0);
    offer_alu(4'd5, mk(4'd5)); offer_lsb(4'd9, mk(4'd9));
    tick(); chk_cdb("t3.c2", 1'b1, 4'd4, mk(4'd4), 1'b0);
    offer_alu(4'd6, mk(4'd6)); lsb_valid = 1'b0;
    tick(); chk_cdb("t3.c3", 1'b1, 4'd8, mk(4'd8), 1'b1);
    chk("t3.c3.alu_ready", 64'(alu_ready), 64'd0);
    offer_alu(4'd12, mk(4'd12));
    tick(); chk_cdb("t3.c4", 1'b1, 4'd5, mk(4'd5), 1'b0);
    chk("t3.c4.alu_ready", 64'(alu_ready), 64'd1);
    tick(); alu_valid = 1'b0;
    chk_cdb("t3.c5", 1'b1, 4'd9, mk(4'd9), 1'b1);
    tick(); chk_cdb("t3.c6", 1'b1, 4'd6, mk(4'd6), 1'b0);
    tick(); chk_cdb("t3.c7", 1'b1, 4'd12, mk(4'd12), 1'b0);
    chk("t3.c7.conflict", 64'(conflict_cnt), 64'd5);
    tick(); chk("t3.c8.valid", 64'(cdb_valid), 64'd0);

    // clear flushes buffered entries, keeps conflict_cnt
    offer_alu(4'd1, mk(4'd1)); offer_lsb(4'd2, mk(4'd2));
    tick();
    offer_alu(4'd3, mk(4'd3)); offer_lsb(4'd4, mk(4'd4));
    tick(); alu_valid = 1'b0; lsb_valid = 1'b0;
    chk_cdb("t4.c2", 1'b1, 4'd2, mk(4'd2), 1'b1);
    chk("t4.c2.conflict", 64'(conflict_cnt), 64'd6);
    clear = 1'b1;
    tick(); clear = 1'b0;
    chk("t4.c3.alu_ready", 64'(alu_ready), 64'd1);
    chk("t4.c3.lsb_ready", 64'(lsb_ready), 64'd1);
    chk_cdb("t4.c3", 1'b0, 4'd2, mk(4'd2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_cdb($sformatf("t4.post%0d", i), 1'b0, 4'd2, mk(4'd2), 1'b1);
    end
    chk("t4.conflict", 64'(conflict_cnt), 64'd6);

    // rdy_in low freezes everything and ignores clear and offers
    offer_alu(4'd5, mk(4'd5)); offer_lsb(4'd6, mk(4'd6));
    tick(); alu_valid = 1'b0; lsb_valid = 1'b0;
    tick(); chk_cdb("t5.c2", 1'b1, 4'd5, mk(4'd5), 1'b0);
    chk("t5.c2.conflict", 64'(conflict_cnt), 64'd7);
    rdy_in = 1'b0; clear = 1'b1; offer_alu(4'd9, mk(4'd9));
    for (int i = 0; i < 3; i++) begin
      tick(); chk_cdb($sformatf("t5.frz%0d", i), 1'b1, 4'd5, mk(4'd5), 1'b0);
      chk($sformatf("t5.frz%0d.conflict", i), 64'(conflict_cnt), 64'd7);
    end
    rdy_in = 1'b1; clear = 1'b0; alu_valid = 1'b0;
    tick(); chk_cdb("t5.resume", 1'b1, 4'd6, mk(4'd6), 1'b1);
    tick(); chk_cdb("t5.idle", 1'b0, 4'd6, mk(4'd6), 1'b1);
    chk("t5.conflict", 64'(conflict_cnt), 64'd7);

    // asynchronous reset mid-operation
    offer_alu(4'd7, mk(4'd7)); offer_lsb(4'd8, mk(4'd8));
    tick(); alu_valid = 1'b0; lsb_valid = 1'b0;
    tick(); chk_cdb("t6.c2", 1'b1, 4'd7, mk(4'd7), 1'b0);
    chk("t6.c2.conflict", 64'(conflict_cnt), 64'd8);
    #2 rst_in = 1'b0;
    #1;
    chk_cdb("t6.async", 1'b0, 4'd0, 32'h0, 1'b0);
    chk("t6.async.conflict", 64'(conflict_cnt), 64'd0);
    chk("t6.async.alu_ready", 64'(alu_ready), 64'd1);
    tick(); rst_in = 1'b1;
    tick(); chk("t6.disc1.valid", 64'(cdb_valid), 64'd0);
    tick(); chk("t6.disc2.valid", 64'(cdb_valid), 64'd0);
    offer_alu(4'hA, mk(4'hA)); offer_lsb(4'hB, mk(4'hB));
    tick(); alu_valid = 1'b0; lsb_valid = 1'b0;
    tick(); chk_cdb("t6.r2", 1'b1, 4'hA, mk(4'hA), 1'b0);
    chk("t6.r2.conflict", 64'(conflict_cnt), 64'd1);
    tick(); chk_cdb("t6.r3", 1'b1, 4'hB, mk(4'hB), 1'b1);
    tick(); chk("t6.r4.valid", 64'(cdb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
